// File: rtl/isa_bus_host_regs_if.sv
// Avalon-MM slave port bundle between the HPS bridge and the ISA host register bank.
interface isa_bus_host_regs_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/isa_bus_host_regs.sv
// Avalon-MM register bank that drives the ISA bus cycle sequencer and tracks its status.
// Optional feature macro: ISA_HOST_IRQ_EN (IRQ_MASK register and registered level irq).
module isa_bus_host_regs #(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    isa_bus_host_regs_if.slave  avs,
    output logic [7:0]          control_out,
    output logic [ADDR_W-1:0]   isa_addr,
    output logic [7:0]          isa_wdata,
    input  logic                data_load_n,
    input  logic                control_reset_n,
    input  logic [7:0]          isa_data_in,
    output logic                busy,
    output logic                irq
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_ADDR     = 3'd1;
    localparam logic [2:0] A_WDATA    = 3'd2;
    localparam logic [2:0] A_RDATA    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;
    localparam logic [2:0] A_IRQ_MASK = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [3:1]         sticky_q, sticky_d;   // [1]=DONE [2]=TIMEOUT [3]=COLLIDE
    logic [2:1]         mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic        wr_ctrl, wr_addr, wr_wdata, wr_status, wr_mask;
    logic [3:1]  sticky_set;
    logic [31:0] rd_word;
    logic        unused_wd;

    assign unused_wd = &{1'b0, avs.avs_writedata};

    assign wr_ctrl   = avs.avs_write && (avs.avs_address == A_CTRL);
    assign wr_addr   = avs.avs_write && (avs.avs_address == A_ADDR);
    assign wr_wdata  = avs.avs_write && (avs.avs_address == A_WDATA);
    assign wr_status = avs.avs_write && (avs.avs_address == A_STATUS);
    assign wr_mask   = avs.avs_write && (avs.avs_address == A_IRQ_MASK);

    assign busy = (state_q != ST_IDLE);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        sticky_d   = sticky_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        irq_d      = 1'b0;
        sticky_set = '0;
        rd_word    = '0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (wr_ctrl) begin
                    if (avs.avs_writedata[0])      state_d = ST_RD;
                    else if (avs.avs_writedata[1]) state_d = ST_WR;
                end
            end
            default: begin
                // Sequencer completion takes priority over the watchdog on the same edge.
                if (!control_reset_n) begin
                    state_d       = ST_IDLE;
                    sticky_set[1] = 1'b1;
                    cnt_d         = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d       = ST_IDLE;
                    sticky_set[2] = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        if (state_q == ST_RD && !data_load_n) rdata_d = isa_data_in;

        if (busy) begin
            sticky_set[3] = wr_ctrl || wr_addr || wr_wdata;
        end else begin
            if (wr_addr)  addr_d  = avs.avs_writedata[ADDR_W-1:0];
            if (wr_wdata) wdata_d = avs.avs_writedata[7:0];
        end

        // Clear first, then set, so a set event on the same edge survives the W1C.
        if (wr_status) sticky_d = sticky_d & ~avs.avs_writedata[3:1];
        sticky_d = sticky_d | sticky_set;

`ifdef ISA_HOST_IRQ_EN
        if (wr_mask) mask_d = avs.avs_writedata[2:1];
        irq_d = |(sticky_q[2:1] & mask_q);
`else
        mask_d = '0;
`endif

        unique case (avs.avs_address)
            A_CTRL:     rd_word = {24'd0, control_out};
            A_ADDR:     rd_word = 32'(addr_q);
            A_WDATA:    rd_word = {24'd0, wdata_q};
            A_RDATA:    rd_word = {24'd0, rdata_q};
            A_STATUS:   rd_word = {28'd0, sticky_q, busy};
`ifdef ISA_HOST_IRQ_EN
            A_IRQ_MASK: rd_word = {29'd0, mask_q, 1'b0};
`endif
            default:    rd_word = '0;
        endcase

        if (avs.avs_read) readdata_d = rd_word;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            sticky_q   <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            sticky_q   <= sticky_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign control_out      = (state_q == ST_RD) ? 8'h01 :
                              (state_q == ST_WR) ? 8'h02 : 8'h00;
    assign isa_addr         = addr_q;
    assign isa_wdata        = wdata_q;
    assign irq              = irq_q;
    assign avs.avs_readdata = readdata_q;

endmodule
